// File: rtl/cart_mem_arbiter_pkg.sv
// Shared types and helpers for the cartridge BRAM port arbiter.
// Holds the requester limit, the read-tag record and the one-hot decoder.
package cart_arb_pkg;

   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] id;
   } rd_tag_t;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/cart_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above start,
// wrapping to index 0, returned as a one-hot grant plus its index.
module rr_pick
   import cart_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!found && req[j] && (j >= int'(start))) begin
            gnt[j] = 1'b1;
            found  = 1'b1;
         end
      end
      // Wrapped part of the search: indices below the start point.
      for (int j = 0; j < N; j++) begin
         if (!found && req[j] && (j < int'(start))) begin
            gnt[j] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign idx = onehot_to_idx(MAX_REQ'(gnt));

endmodule

// File: rtl/cart_mem_arbiter.sv
// Round-robin arbiter with per-requester lock sharing one cartridge BRAM port.
// Optional build macro CART_ARB_FIXED_PRIO_EN gives requester 0 absolute priority.
module cart_mem_arbiter
   import cart_arb_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_COL    = 4,
   parameter int COL_WIDTH  = 8,
   parameter int DATA_WIDTH = NUM_COL*COL_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_lock,
   input  logic [NUM_REQ*NUM_COL-1:0]    req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          mem_en,
   output logic [NUM_COL-1:0]            mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_din,
   input  logic [DATA_WIDTH-1:0]         mem_dout
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  lock_valid_q, lock_valid_d;
   logic [IDX_W-1:0]      lock_id_q, lock_id_d;
   logic                  mem_en_q, mem_en_d;
   logic [NUM_COL-1:0]    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   rd_tag_t               tag1_q, tag1_d;
   rd_tag_t               tag2_q, tag2_d;

   logic [NUM_REQ-1:0]    rr_req, rr_gnt, lock_oh, gnt_c;
   logic [IDX_W-1:0]      rr_idx, gnt_idx;
   logic                  prio0, lock_hit, sel_lock;
   logic [NUM_COL-1:0]    sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef CART_ARB_FIXED_PRIO_EN
   assign prio0  = req[0];
   assign rr_req = req & ~ONE;
`else
   assign prio0  = 1'b0;
   assign rr_req = req;
`endif

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req   (rr_req),
      .start (rr_ptr_q),
      .gnt   (rr_gnt),
      .idx   (rr_idx)
   );

   // Handshake: an access is accepted on the rising edge where its gnt bit is
   // high; req/we/addr/wdata must stay stable from req rising until that edge.
   always_comb begin
      lock_oh  = ONE << lock_id_q;
      lock_hit = lock_valid_q && (|(req & lock_oh));
      gnt_c    = '0;
      gnt_idx  = '0;
      if (!rst) begin
         if (prio0) begin
            gnt_c   = ONE;
            gnt_idx = '0;
         end else if (lock_hit) begin
            gnt_c   = lock_oh;
            gnt_idx = lock_id_q;
         end else begin
            gnt_c   = rr_gnt;
            gnt_idx = rr_idx;
         end
      end
   end

   always_comb begin
      sel_we    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_lock  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i]) begin
            sel_we    = req_we[i*NUM_COL +: NUM_COL];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_lock  = req_lock[i];
         end
      end

      rr_ptr_d     = rr_ptr_q;
      // An owner that dropped req loses the lock at this edge.
      lock_valid_d = lock_hit;
      lock_id_d    = lock_id_q;
      mem_en_d     = |gnt_c;
      mem_we_d     = '0;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      tag1_d.valid = (|gnt_c) && (sel_we == '0);
      tag1_d.id    = gnt_idx;
      tag2_d       = tag1_q;

      if (|gnt_c) begin
         mem_we_d   = sel_we;
         mem_addr_d = sel_addr;
         mem_din_d  = sel_wdata;
         if (!prio0) begin
            if (sel_lock) begin
               lock_valid_d = 1'b1;
               lock_id_d    = gnt_idx;
            end else begin
               lock_valid_d = 1'b0;
               rr_ptr_d     = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         lock_valid_q <= 1'b0;
         lock_id_q    <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= '0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         tag1_q       <= '0;
         tag2_q       <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
      end
   end

   assign gnt      = gnt_c;
   assign rvalid   = (tag2_q.valid && !rst) ? (ONE << tag2_q.id) : '0;
   assign rdata    = mem_dout;
   assign mem_en   = mem_en_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed-vector bench for cart_mem_arbiter with a behavioural read-first BRAM.
// Define CART_ARB_FIXED_PRIO_EN for both bench and RTL to exercise fixed priority.
module tb_cart_mem_arbiter;

   localparam int NUM_REQ    = 3;
   localparam int ADDR_WIDTH = 10;
   localparam int NUM_COL    = 4;
   localparam int DATA_WIDTH = 32;
   localparam logic [31:0] D1 = 32'h5A000001;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_REQ-1:0]            req, req_lock, gnt, rvalid;
   logic [NUM_REQ*NUM_COL-1:0]    req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [DATA_WIDTH-1:0]         rdata, mem_din, mem_dout;
   logic                          mem_en;
   logic [NUM_COL-1:0]            mem_we;
   logic [ADDR_WIDTH-1:0]         mem_addr;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   cart_mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_lock  (req_lock),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   // ---------------- BRAM model (1-cycle latency, read-first, byte lanes) ----------------
   logic [31:0]   mem_arr [0:1023];
   logic [1023:0] written;
   logic [31:0]   cur_w, nxt_w;

   function automatic logic [31:0] init_word(input logic [9:0] a);
      return 32'h5A000000 | {22'h0, a};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         written <= '0;
      end else if (mem_en) begin
         cur_w = written[mem_addr] ? mem_arr[mem_addr] : init_word(mem_addr);
         mem_dout <= cur_w;
         if (|mem_we) begin
            nxt_w = cur_w;
            for (int k = 0; k < NUM_COL; k++) begin
               if (mem_we[k]) nxt_w[k*8 +: 8] = mem_din[k*8 +: 8];
            end
            mem_arr[mem_addr] <= nxt_w;
            written[mem_addr] <= 1'b1;
         end
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  lock;
      logic [3:0]  we;
      logic [9:0]  addr;
      logic [31:0] wd;
      logic [2:0]  g;
      logic [2:0]  rv;
      logic        en;
      logic [31:0] rd;
      logic        chk_cmd;
      logic [3:0]  cwe;
      logic [9:0]  caddr;
      logic [31:0] cdin;
   } vec_t;

   vec_t tbl[$];
   vec_t seq[$];

   function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                               input logic [3:0] we, input logic [9:0] ad, input logic [31:0] wd,
                               input logic [2:0] g, input logic [2:0] rv, input logic en,
                               input logic [31:0] rd = 32'h0, input logic chk_cmd = 1'b0,
                               input logic [3:0] cwe = 4'h0, input logic [9:0] caddr = 10'h0,
                               input logic [31:0] cdin = 32'h0);
      vec_t v;
      v.rst = r;  v.req = rq; v.lock = lk; v.we = we; v.addr = ad; v.wd = wd;
      v.g = g;    v.rv = rv;  v.en = en;   v.rd = rd;
      v.chk_cmd = chk_cmd; v.cwe = cwe; v.caddr = caddr; v.cdin = cdin;
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic apply(input vec_t v, input string name);
      @(posedge clk);
      #1;
      rst       = v.rst;
      req       = v.req;
      req_lock  = v.lock;
      req_we    = {NUM_REQ{v.we}};
      req_addr  = {NUM_REQ{v.addr}};
      req_wdata = {NUM_REQ{v.wd}};
      @(negedge clk);
      check({name, ".gnt"},    32'(gnt),    32'(v.g));
      check({name, ".rvalid"}, 32'(rvalid), 32'(v.rv));
      check({name, ".mem_en"}, 32'(mem_en), 32'(v.en));
      if (v.rv != 3'b000) check({name, ".rdata"}, rdata, v.rd);
      if (v.chk_cmd) begin
         check({name, ".mem_we"},   32'(mem_we),   32'(v.cwe));
         check({name, ".mem_addr"}, 32'(mem_addr), 32'(v.caddr));
         check({name, ".mem_din"},  mem_din,       v.cdin);
      end
   endtask

   // ---------------- test ----------------
   initial begin
      rst = 1'b1; req = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;

      apply(mk(1, 3'b000, 3'b000, 4'h0, 10'h0, 32'h0, 3'b000, 3'b000, 1'b0,
               32'h0, 1'b1, 4'h0, 10'h0, 32'h0), "reset");

`ifdef CART_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++)
         seq.push_back(mk(0, 3'b111, 3'b000, 4'h0, 10'h1, 32'h0, 3'b001,
                          (i >= 2) ? 3'b001 : 3'b000, (i != 0), D1));
      seq.push_back(mk(0, 3'b110, 3'b000, 4'h0, 10'h1, 32'h0, 3'b010, 3'b001, 1'b1, D1));
      seq.push_back(mk(0, 3'b110, 3'b000, 4'h0, 10'h1, 32'h0, 3'b100, 3'b001, 1'b1, D1));
      seq.push_back(mk(0, 3'b110, 3'b000, 4'h0, 10'h1, 32'h0, 3'b010, 3'b010, 1'b1, D1));
      foreach (seq[i]) apply(seq[i], $sformatf("prio%0d", i));
`else
      // Round-robin reads from all three requesters.
      tbl.push_back(mk(0, 3'b111, 3'b000, 4'h0, 10'h1, 32'h0, 3'b001, 3'b000, 1'b0));
      tbl.push_back(mk(0, 3'b111, 3'b000, 4'h0, 10'h1, 32'h0, 3'b010, 3'b000, 1'b1));
      tbl.push_back(mk(0, 3'b111, 3'b000, 4'h0, 10'h1, 32'h0, 3'b100, 3'b001, 1'b1, D1));
      tbl.push_back(mk(0, 3'b111, 3'b000, 4'h0, 10'h1, 32'h0, 3'b001, 3'b010, 1'b1, D1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b100, 1'b1, D1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b001, 1'b0, D1));
      // Full write by requester 1, then read by requester 2.
      tbl.push_back(mk(0, 3'b010, 3'b000, 4'hF, 10'h5, 32'hA1B2C3D4, 3'b010, 3'b000, 1'b0));
      tbl.push_back(mk(0, 3'b100, 3'b000, 4'h0, 10'h5, 32'h0, 3'b100, 3'b000, 1'b1,
                       32'h0, 1'b1, 4'hF, 10'h5, 32'hA1B2C3D4));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h0, 32'h0, 3'b000, 3'b000, 1'b1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h0, 32'h0, 3'b000, 3'b100, 1'b0, 32'hA1B2C3D4));
      // Byte-lane write to lane 1, then read back.
      tbl.push_back(mk(0, 3'b001, 3'b000, 4'h2, 10'h5, 32'h0000EE00, 3'b001, 3'b000, 1'b0));
      tbl.push_back(mk(0, 3'b001, 3'b000, 4'h0, 10'h5, 32'h0, 3'b001, 3'b000, 1'b1,
                       32'h0, 1'b1, 4'h2, 10'h5, 32'h0000EE00));
      tbl.push_back(mk(0, 3'b100, 3'b000, 4'h0, 10'h1, 32'h0, 3'b100, 3'b000, 1'b1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h0, 32'h0, 3'b000, 3'b001, 1'b1, 32'hA1B2EED4));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h0, 32'h0, 3'b000, 3'b100, 1'b0, D1));
      // Lock: requester 0 holds for three accesses against requester 1.
      tbl.push_back(mk(0, 3'b011, 3'b001, 4'h0, 10'h1, 32'h0, 3'b001, 3'b000, 1'b0));
      tbl.push_back(mk(0, 3'b011, 3'b001, 4'h0, 10'h1, 32'h0, 3'b001, 3'b000, 1'b1));
      tbl.push_back(mk(0, 3'b011, 3'b000, 4'h0, 10'h1, 32'h0, 3'b001, 3'b001, 1'b1, D1));
      tbl.push_back(mk(0, 3'b011, 3'b000, 4'h0, 10'h1, 32'h0, 3'b010, 3'b001, 1'b1, D1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b001, 1'b1, D1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b010, 1'b0, D1));
      // Lock owner drops req: same-cycle fallback to round-robin.
      tbl.push_back(mk(0, 3'b001, 3'b001, 4'h0, 10'h1, 32'h0, 3'b001, 3'b000, 1'b0));
      tbl.push_back(mk(0, 3'b110, 3'b000, 4'h0, 10'h1, 32'h0, 3'b100, 3'b000, 1'b1));
      tbl.push_back(mk(0, 3'b110, 3'b000, 4'h0, 10'h1, 32'h0, 3'b010, 3'b001, 1'b1, D1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b100, 1'b1, D1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b010, 1'b0, D1));
      foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

      // Reset one cycle after a locked read grant.
      seq.push_back(mk(0, 3'b010, 3'b010, 4'h0, 10'h1, 32'h0, 3'b010, 3'b000, 1'b0));
      seq.push_back(mk(1, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b000, 1'b1));
      seq.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b000, 1'b0,
                       32'h0, 1'b1, 4'h0, 10'h0, 32'h0));
      seq.push_back(mk(0, 3'b011, 3'b000, 4'h0, 10'h1, 32'h0, 3'b001, 3'b000, 1'b0));
      seq.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b000, 1'b1));
      seq.push_back(mk(0, 3'b000, 3'b000, 4'h0, 10'h1, 32'h0, 3'b000, 3'b001, 1'b0, D1));
      foreach (seq[i]) apply(seq[i], $sformatf("rstseq%0d", i));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
